uart_baud_gen_frac: RTL and testbench

Parametrised fractional baud-rate generator for the UART. It produces an oversample tick (`tick_rx`) and a bit-rate tick (`tick_tx`, one per OVERSAMPLE oversample ticks) from a divisor that is programmable at run time. The divisor has an integer part and a fractional part, so non-integer clock/baud ratios hold their average rate exactly. It replaces the fixed-divisor tick generator and feeds both the RX sampler and the TX shifter.

---
 rtl/uart_baud_gen_frac_if.sv | 26 ++
 rtl/uart_baud_gen_frac.sv | 155 +++++++++++++++
 tb/tb_uart_baud_gen_frac.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_baud_gen_frac_if.sv
// Control and tick bundle of the fractional baud generator: divisor programming,
// phase resync and the RX/TX tick outputs.
interface uart_baud_gen_frac_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
);
    logic              en;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              resync;
    logic              tick_rx;
    logic              tick_tx;
    logic              div_pending;
    logic              cfg_err;

    modport master (
        output en, div_int, div_frac, div_load, resync,
        input  tick_rx, tick_tx, div_pending, cfg_err
    );

    modport slave (
        input  en, div_int, div_frac, div_load, resync,
        output tick_rx, tick_tx, div_pending, cfg_err
    );
endinterface

// File: rtl/uart_baud_gen_frac.sv
// Fractional baud-rate generator: oversample tick every act_int(+1) clocks so the
// average period is act_int + act_frac/2^FRAC_W, plus a bit tick every OVERSAMPLE ticks.
module uart_baud_gen_frac #(
    parameter int DIV_W            = 16,
    parameter int FRAC_W           = 4,
    parameter int OVERSAMPLE       = 16,
    parameter int DEFAULT_DIV_INT  = 651,
    parameter int DEFAULT_DIV_FRAC = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_baud_gen_frac_if.slave  bus
);
    localparam int                CNT_W        = DIV_W + 1;
    localparam int                SUB_W        = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [SUB_W-1:0]  SUB_LAST     = SUB_W'(OVERSAMPLE - 1);
    localparam logic [SUB_W-1:0]  SUB_ONE      = SUB_W'(1);
    localparam logic [SUB_W-1:0]  SUB_ZERO     = SUB_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO     = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_RST      = CNT_W'(DEFAULT_DIV_INT - 1);
    localparam logic [DIV_W-1:0]  DIV_MIN      = DIV_W'(2);
    localparam logic [DIV_W-1:0]  ACT_INT_RST  = DIV_W'(DEFAULT_DIV_INT);
    localparam logic [FRAC_W-1:0] ACT_FRAC_RST = FRAC_W'(DEFAULT_DIV_FRAC);
    localparam logic [FRAC_W-1:0] FRAC_ZERO    = FRAC_W'(0);

    // Fraction accumulator step; the MSB is the carry that stretches a period by one clock.
    function automatic logic [FRAC_W:0] frac_add(input logic [FRAC_W-1:0] a,
                                                 input logic [FRAC_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [DIV_W-1:0]  act_int_r, act_int_s;
    logic [FRAC_W-1:0] act_frac_r, act_frac_s;
    logic [DIV_W-1:0]  pend_int_r, pend_int_s;
    logic [FRAC_W-1:0] pend_frac_r, pend_frac_s;
    logic              pend_r, pend_s;
    logic [FRAC_W-1:0] acc_r, acc_s;
    logic [SUB_W-1:0]  sub_r, sub_s;
    logic              tick_rx_r, tick_rx_s;
    logic              tick_tx_r, tick_tx_s;
    logic              cfg_err_r, cfg_err_s;
    logic              load_ok_s;
    logic [FRAC_W:0]   frac_sum_s;

    // Next-state logic: resync beats boundary beats plain decrement.
    always_comb begin
        cnt_s       = cnt_r;
        act_int_s   = act_int_r;
        act_frac_s  = act_frac_r;
        pend_int_s  = pend_int_r;
        pend_frac_s = pend_frac_r;
        pend_s      = pend_r;
        acc_s       = acc_r;
        sub_s       = sub_r;
        tick_rx_s   = 1'b0;
        tick_tx_s   = 1'b0;
        cfg_err_s   = cfg_err_r;
        load_ok_s   = bus.div_load && (bus.div_int >= DIV_MIN);
        frac_sum_s  = frac_add(acc_r, act_frac_r);

        if (bus.resync) begin
            // A divisor loaded in this same cycle wins over an older pending one.
            if (load_ok_s) begin
                act_int_s  = bus.div_int;
                act_frac_s = bus.div_frac;
                pend_s     = 1'b0;
            end else if (pend_r) begin
                act_int_s  = pend_int_r;
                act_frac_s = pend_frac_r;
                pend_s     = 1'b0;
            end else begin
                act_int_s  = act_int_r;
                act_frac_s = act_frac_r;
            end
            cnt_s = {1'b0, act_int_s} - CNT_ONE;
            sub_s = SUB_ZERO;
            acc_s = FRAC_ZERO;
        end else if (bus.en && (cnt_r == CNT_ZERO)) begin
            tick_rx_s = 1'b1;
            if (sub_r == SUB_LAST) begin
                sub_s     = SUB_ZERO;
                tick_tx_s = 1'b1;
            end else begin
                sub_s     = sub_r + SUB_ONE;
                tick_tx_s = 1'b0;
            end
            if (pend_r) begin
                act_int_s  = pend_int_r;
                act_frac_s = pend_frac_r;
                pend_s     = 1'b0;
                acc_s      = FRAC_ZERO;
                cnt_s      = {1'b0, pend_int_r} - CNT_ONE;
            end else begin
                acc_s = frac_sum_s[FRAC_W-1:0];
                cnt_s = {1'b0, act_int_r} - CNT_ONE + {{DIV_W{1'b0}}, frac_sum_s[FRAC_W]};
            end
        end else if (bus.en) begin
            cnt_s = cnt_r - CNT_ONE;
        end else begin
            cnt_s = cnt_r;
        end

        // Without resync a valid load lands in the pending register (last one wins).
        if (load_ok_s && !bus.resync) begin
            pend_int_s  = bus.div_int;
            pend_frac_s = bus.div_frac;
            pend_s      = 1'b1;
        end else begin
            pend_int_s  = pend_int_s;
            pend_frac_s = pend_frac_s;
        end

        if (bus.div_load) begin
            cfg_err_s = !load_ok_s;
        end else begin
            cfg_err_s = cfg_err_r;
        end
    end

    // State and registered outputs; reset discards any pending divisor.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r       <= CNT_RST;
            act_int_r   <= ACT_INT_RST;
            act_frac_r  <= ACT_FRAC_RST;
            pend_int_r  <= {DIV_W{1'b0}};
            pend_frac_r <= FRAC_ZERO;
            pend_r      <= 1'b0;
            acc_r       <= FRAC_ZERO;
            sub_r       <= SUB_ZERO;
            tick_rx_r   <= 1'b0;
            tick_tx_r   <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            cnt_r       <= cnt_s;
            act_int_r   <= act_int_s;
            act_frac_r  <= act_frac_s;
            pend_int_r  <= pend_int_s;
            pend_frac_r <= pend_frac_s;
            pend_r      <= pend_s;
            acc_r       <= acc_s;
            sub_r       <= sub_s;
            tick_rx_r   <= tick_rx_s;
            tick_tx_r   <= tick_tx_s;
            cfg_err_r   <= cfg_err_s;
        end
    end

    assign bus.tick_rx     = tick_rx_r;
    assign bus.tick_tx     = tick_tx_r;
    assign bus.div_pending = pend_r;
    assign bus.cfg_err     = cfg_err_r;
endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Scoreboard bench for uart_baud_gen_frac: a period-level reference model predicts the
// outputs after every clock edge; a monitor pops and compares each cycle.
module tb_uart_baud_gen_frac;
    localparam int OS   = 16;
    localparam int DDEF = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    logic [3:0] exp_q[$];

    // Reference model state: divisor values and clocks remaining to the next tick.
    int m_int, m_frac, p_int, p_frac, left, nb, txc;
    bit m_pend, m_err;

    uart_baud_gen_frac_if #(.DIV_W(16), .FRAC_W(4)) bus ();

    uart_baud_gen_frac #(
        .DIV_W(16), .FRAC_W(4), .OVERSAMPLE(OS),
        .DEFAULT_DIV_INT(DDEF), .DEFAULT_DIV_FRAC(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int fl(input int n, input int f);
        return (n * f) / 16;
    endfunction

    task automatic model_reset();
        m_int = DDEF; m_frac = 0; p_int = 0; p_frac = 0;
        m_pend = 1'b0; m_err = 1'b0; left = DDEF; nb = 0; txc = 0;
    endtask

    // Effect of one rising edge. Period after the nb-th boundary since the fraction
    // restarted is m_int plus the increase of floor(nb*frac/16).
    task automatic model_edge(input bit en, input bit ld, input int di, input int df,
                              input bit rs, output bit rx, output bit tx);
        bit lok;
        lok = ld && (di >= 2);
        rx = 1'b0; tx = 1'b0;
        if (rs) begin
            if (lok) begin
                m_int = di; m_frac = df; m_pend = 1'b0;
            end else if (m_pend) begin
                m_int = p_int; m_frac = p_frac; m_pend = 1'b0;
            end
            left = m_int; nb = 0; txc = 0;
        end else if (en) begin
            left = left - 1;
            if (left == 0) begin
                rx  = 1'b1;
                txc = (txc + 1) % OS;
                tx  = (txc == 0);
                if (m_pend) begin
                    m_int = p_int; m_frac = p_frac; m_pend = 1'b0;
                    nb = 0; left = m_int;
                end else begin
                    nb = nb + 1;
                    left = m_int + fl(nb, m_frac) - fl(nb - 1, m_frac);
                end
            end
        end
        if (lok && !rs) begin
            p_int = di; p_frac = df; m_pend = 1'b1;
        end
        if (ld) m_err = !lok;
    endtask

    // Called at a falling edge: drive inputs, queue the expectation, advance a cycle.
    task automatic step(input bit en, input bit ld, input int di, input int df, input bit rs);
        bit rx, tx;
        bus.en       = en;
        bus.div_load = ld;
        bus.div_int  = 16'(di);
        bus.div_frac = 4'(df);
        bus.resync   = rs;
        model_edge(en, ld, di, df, rs, rx, tx);
        exp_q.push_back({rx, tx, m_pend, m_err});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, got, req);
        end
    endtask

    // Monitor: one expectation per clock edge while out of reset.
    initial begin
        logic [3:0] e, g;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                g = {bus.tick_rx, bus.tick_tx, bus.div_pending, bus.cfg_err};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL no_expectation cycle %0d: got rx/tx/pend/err %b", cyc, g);
                end else begin
                    e = exp_q.pop_front();
                    if (g !== e) begin
                        errors++;
                        $display("FAIL outputs cycle %0d: got rx/tx/pend/err %b required %b",
                                 cyc, g, e);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0;
        bus.en = 1'b0; bus.div_load = 1'b0; bus.div_int = 16'd0;
        bus.div_frac = 4'd0; bus.resync = 1'b0;
        model_reset();
        #1;
        check_bit("reset_tick_rx", bus.tick_rx, 1'b0);
        check_bit("reset_tick_tx", bus.tick_tx, 1'b0);
        check_bit("reset_pending", bus.div_pending, 1'b0);
        check_bit("reset_cfg_err", bus.cfg_err, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Default integer divisor, through the first bit tick at edge 64.
        idle(70);
        // Fractional 4 + 8/16, applied by resync.
        step(1'b1, 1'b1, 4, 8, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b1);
        idle(200);
        // Divisor 4, then load 6 two clocks into the period.
        step(1'b1, 1'b1, 4, 0, 1'b1);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b1, 6, 0, 1'b0);
        idle(30);
        // Invalid load, then a valid load of 5.
        step(1'b1, 1'b1, 1, 0, 1'b0);
        idle(10);
        step(1'b1, 1'b1, 5, 0, 1'b0);
        idle(30);
        // Enable low for 10 cycles, with a load accepted while frozen.
        for (int i = 0; i < 10; i++) step(1'b0, (i == 4), 3, 2, 1'b0);
        idle(20);
        // Resync with divisor 4 restarts the bit phase.
        step(1'b1, 1'b1, 4, 0, 1'b1);
        idle(80);
        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 8) != 0, ($urandom % 40) == 0,
                 int'($urandom_range(0, 9)), int'($urandom % 16), ($urandom % 60) == 0);
        end
        // Asynchronous reset with a load pending.
        step(1'b1, 1'b1, 7, 3, 1'b0);
        idle(1);
        #2;
        rst = 1'b0;
        #1;
        check_bit("async_tick_rx", bus.tick_rx, 1'b0);
        check_bit("async_tick_tx", bus.tick_tx, 1'b0);
        check_bit("async_pending", bus.div_pending, 1'b0);
        check_bit("async_cfg_err", bus.cfg_err, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(40);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked expectations required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
